// File: rtl/calcrd_pkg.sv
// -----------------------------------------------------------------------------
// calcrd_pkg
// Shared definitions for the calc line-buffer reader (calcram_reader) and its
// output FIFO (calcrd_fifo).
//   - default geometry: ADDR_W_DEF, PIX_W_DEF, LINE_LEN_DEF, IDX_W_DEF
//   - FIFO_DEPTH and the derived pointer/count widths
//   - SHIFT_W: width of the calc move value used by the optional shift input
//   - state_t: reader FSM states {IDLE, READ, DRAIN}
//   - pair_t : one output pair {f, g, idx, last} at the default widths
// -----------------------------------------------------------------------------
package calcrd_pkg;

    localparam int ADDR_W_DEF   = 11;
    localparam int PIX_W_DEF    = 3;
    localparam int LINE_LEN_DEF = 640;
    localparam int IDX_W_DEF    = 10;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam int SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_W_DEF-1:0] f;
        logic [PIX_W_DEF-1:0] g;
        logic [IDX_W_DEF-1:0] idx;
        logic                 last;
    } pair_t;

endpackage

// File: rtl/calcrd_fifo.sv
// -----------------------------------------------------------------------------
// calcrd_fifo
// FIFO_DEPTH-entry synchronous FIFO holding packed pixel-pair entries. The
// current occupancy is exported so the reader can throttle RAM reads and never
// overrun the FIFO. Push and pop in the same cycle are both honoured.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears pointers/count)
//   push, din     write an entry (caller guarantees not full)
//   pop           remove the head entry (caller guarantees not empty)
//   dout          head entry (meaningful only when !empty)
//   count         number of stored entries, 0..FIFO_DEPTH
//   empty         count == 0
// -----------------------------------------------------------------------------
module calcrd_fifo
    import calcrd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries data only and is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);

endmodule

// File: rtl/calcram_reader.sv
// -----------------------------------------------------------------------------
// calcram_reader
// Reads one line of LINE_LEN pixel pairs from the right (f) and left (g) calc
// line-buffer RAMs in lockstep and streams them to the disparity calculator
// over a valid/ready handshake. RAM reads have one cycle of registered latency;
// reads are only issued while FIFO occupancy plus the read in flight leaves
// room, so no data is ever dropped regardless of out_ready.
//
// Optional build macro: CALCRD_SHIFT_EN
//   defined  : adds input shift (SHIFT_W bits, latched with start); the left
//              RAM is read at base+idx+shift, and out_g is zero-padded when
//              idx+shift >= LINE_LEN.
//   undefined: no shift port; address_g == address_f.
//
// Ports:
//   clk, rst             calc clock, synchronous active-high reset
//   start, base_addr     one-cycle line request and its first RAM address
//   shift                left-camera offset (CALCRD_SHIFT_EN only)
//   busy, done           line in progress / one-cycle completion pulse
//   address_f/_g, rden   read port to right/left RAM
//   fdata, gdata         RAM read data, valid the cycle after rden
//   out_valid/out_ready  output handshake
//   out_f, out_g         right/left pixel
//   out_idx, out_last    pixel index within the line, last-pixel flag
// -----------------------------------------------------------------------------
module calcram_reader
    import calcrd_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int LINE_LEN = LINE_LEN_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
`ifdef CALCRD_SHIFT_EN
    input  logic [SHIFT_W-1:0] shift,
`endif
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  address_f,
    output logic [ADDR_W-1:0]  address_g,
    output logic               rden,
    input  logic [PIX_W-1:0]   fdata,
    input  logic [PIX_W-1:0]   gdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_f,
    output logic [PIX_W-1:0]   out_g,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

    typedef struct packed {
        logic [PIX_W-1:0] f;
        logic [PIX_W-1:0] g;
        logic [IDX_W-1:0] idx;
        logic             last;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_r;
    logic [IDX_W-1:0]  issue_idx;
    logic              accept;

    // Read in its q cycle: the RAM output is valid and gets pushed.
    logic              rd_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              room;
    entry_t            push_entry;
    entry_t            head_entry;
    logic [ENTRY_W-1:0] head_bits;

`ifdef CALCRD_SHIFT_EN
    logic [SHIFT_W-1:0] shift_r;
    logic [31:0]        idx_plus_shift;
    logic               pad;
    logic               pad_q;
`endif

    // Reads already issued but not yet in the FIFO count against its space.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rd_q);
    assign room      = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    assign address_f = base_r + ADDR_W'(issue_idx);

`ifdef CALCRD_SHIFT_EN
    assign address_g      = address_f + ADDR_W'(shift_r);
    assign idx_plus_shift = 32'(issue_idx) + 32'(shift_r);
    assign pad            = (idx_plus_shift >= 32'(LINE_LEN));
`else
    assign address_g = address_f;
`endif

    always_comb begin
        state_nx = state;
        rden     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                rden = room;
                if (room && (issue_idx == LAST_IDX)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // Empty FIFO with nothing in flight means the last pair has
                // already been handshaken.
                if (fifo_empty && !rd_q) begin
                    done     = 1'b1;
                    state_nx = start ? READ : IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign accept = start && ((state == IDLE) || done);

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_r    <= '0;
            issue_idx <= '0;
            rd_q      <= 1'b0;
`ifdef CALCRD_SHIFT_EN
            shift_r   <= '0;
`endif
        end else begin
            state <= state_nx;
            rd_q  <= rden;
            if (accept) begin
                base_r    <= base_addr;
                issue_idx <= '0;
`ifdef CALCRD_SHIFT_EN
                shift_r   <= shift;
`endif
            end else if (rden) begin
                issue_idx <= issue_idx + IDX_W'(1);
            end
        end
    end

    // Issue -> q stage: tag travelling alongside the RAM read
    always_ff @(posedge clk) begin
        if (rden) begin
            idx_q  <= issue_idx;
            last_q <= (issue_idx == LAST_IDX);
`ifdef CALCRD_SHIFT_EN
            pad_q  <= pad;
`endif
        end
    end

    always_comb begin
        push_entry.f    = fdata;
`ifdef CALCRD_SHIFT_EN
        push_entry.g    = pad_q ? '0 : gdata;
`else
        push_entry.g    = gdata;
`endif
        push_entry.idx  = idx_q;
        push_entry.last = last_q;
    end

    assign fifo_push = rd_q;
    assign fifo_pop  = out_valid && out_ready;

    calcrd_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_bits),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // q -> output: FIFO head, forced to zero whenever nothing is presented
    assign head_entry = entry_t'(head_bits);
    assign out_valid  = !fifo_empty;
    assign out_f      = out_valid ? head_entry.f    : '0;
    assign out_g      = out_valid ? head_entry.g    : '0;
    assign out_idx    = out_valid ? head_entry.idx  : '0;
    assign out_last   = out_valid ? head_entry.last : 1'b0;

endmodule

// File: doc/calcram_reader.md
Name: calcram_reader

Overview:
Reads the per-camera calc line buffers (dataram, 3-bit pixels, 11-bit address) written by the cam2ram blocks. It streams left/right pixel pairs to the disparity calculator over a valid/ready handshake.
It is the read side of the cam2ram calc write path and replaces free-running address generation inside the calc logic.
Both RAMs are read in lockstep on the shared calc clock.

Parameters:
ADDR_W, 11, RAM address width (2048 entries)
PIX_W, 3, pixel width per camera
LINE_LEN, 640, pixels read per start request (1..2^ADDR_W)
IDX_W, 10, width of out_idx (>= clog2(LINE_LEN))

Ports:
clk  in  1  calc clock (sysclk domain)
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to read one line
base_addr  in  ADDR_W  first address of the line, sampled with start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the line has fully drained
address_f  out  ADDR_W  right dataram rdaddress
address_g  out  ADDR_W  left dataram rdaddress
rden  out  1  read enable to both RAMs
fdata  in  PIX_W  right RAM q (1-cycle registered read latency)
gdata  in  PIX_W  left RAM q
out_valid  out  1  pixel pair available
out_ready  in  1  consumer accepts the pair
out_f  out  PIX_W  right pixel
out_g  out  PIX_W  left pixel
out_idx  out  IDX_W  pixel index within the line, 0..LINE_LEN-1
out_last  out  1  high with the pair at idx LINE_LEN-1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, with rst taking priority over all other events.
- Reset values: state IDLE; busy, done, rden, out_valid and out_last are 0; address_f, address_g, out_f, out_g and out_idx are 0; FIFO empty; in-flight count 0.
- IDLE state:
  - start=1 latches base_addr, clears the issue index, and moves to READ.
  - start received while not IDLE is ignored.
- READ state:
  - rden=1 only when fifo_count + inflight < 4.
  - address_f = address_g = (base + issue_idx) mod 2^ADDR_W. Wrap-around is silent.
  - issue_idx increments on each issued read.
  - After LINE_LEN issues, move to DRAIN.
- Read pipeline:
  - A read is in flight for 2 cycles: the issue cycle, then the q cycle.
  - In the q cycle, {fdata, gdata, idx} is pushed into the FIFO.
  - First out_valid appears 2 cycles after the first rden, i.e. start at cycle k, rden at k+1, out_valid at k+3.
- Output FIFO:
  - 4 entries, FIFO head drives out_*.
  - A pop occurs on out_valid & out_ready. Push and pop in the same cycle are both honoured.
  - With out_ready held at 1, throughput is one pair per cycle and no gaps after the first pair.
  - out_* hold stable while out_valid & !out_ready.
- DRAIN state:
  - rden=0.
  - When the FIFO is empty, inflight=0, and the final pair has been handshaken: done=1 for one cycle, busy=0 in that same cycle, and the state returns to IDLE.
  - A start arriving in the done cycle is accepted.
- Ordering: pairs leave strictly in address order. There is no loss, duplication, or reordering under any out_ready pattern.
- Reset mid-line: FIFO and in-flight reads are discarded. Late RAM q data is not captured.

Optional Feature:
Macro CALCRD_SHIFT_EN.
- Defined:
  - Adds input `shift` (6 bits, same width as the calc move value), latched with start.
  - address_g = (base + issue_idx + shift) mod 2^ADDR_W.
  - For issue_idx + shift >= LINE_LEN, out_g is forced to 0 (zero padding). The left RAM is still read, but its data is discarded.
- Undefined: no shift port; address_g = address_f.

Decomposition:
- Package calcrd_pkg holds:
  - default ADDR_W, PIX_W and LINE_LEN;
  - FIFO_DEPTH=4;
  - the state enum {IDLE, READ, DRAIN};
  - the pair entry struct {f, g, idx, last}.
- Sub-module calcrd_fifo: 4-entry synchronous FIFO of entries, exposing count for issue gating.

Test Plan:
1. LINE_LEN=8, base=0, RAM f[a]=a%8, g[a]=7-a%8, out_ready=1, start at cycle 0:
   - rden in cycles 1..8;
   - out_valid in cycles 3..10 with idx 0..7;
   - out_last at cycle 10, done at cycle 11.
2. Same setup with out_ready toggling 1,0,1,0:
   - all 8 pairs are delivered in order, none duplicated;
   - rden is never high when fifo_count+inflight=4;
   - out_* are stable while stalled.
3. base=2044, LINE_LEN=8:
   - address sequence 2044, 2045, 2046, 2047, 0, 1, 2, 3;
   - out_idx runs 0..7.
4. Start while busy:
   - start pulse at cycle 4 is ignored, and exactly 8 pairs are produced;
   - start in the done cycle begins a new line with idx 0 and rden on the next cycle.
5. rst held for one cycle after 3 pairs have been popped:
   - next cycle: all outputs 0, busy=0, out_valid=0;
   - a following start yields idx 0..7 from the new base.
6. CALCRD_SHIFT_EN with shift=3, LINE_LEN=8, base=0:
   - address_g = idx+3;
   - out_g = 0 for idx 5..7;
   - out_f is unaffected.
